and3_event_qualifier: RTL and testbench



---
 rtl/and3_event_qualifier_if.sv | 24 ++
 rtl/and3_event_qualifier.sv | 152 +++++++++++++++
 tb/tb_and3_event_qualifier.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/and3_event_qualifier_if.sv
// Bundle of the qualifier's data-path signals: raw AND-tree input and controls
// going in, qualified level, edge pulses and event count coming out.
interface and3_event_qualifier_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 d;
  logic                 en;
  logic                 clr;
  logic                 q;
  logic                 rise;
  logic                 fall;
  logic [CNT_WIDTH-1:0] count;
  logic                 ovf;

  modport master (
    output d, en, clr,
    input  q, rise, fall, count, ovf
  );

  modport slave (
    input  d, en, clr,
    output q, rise, fall, count, ovf
  );
endinterface

// File: rtl/and3_event_qualifier.sv
// Synchronises the raw 3-input AND output, debounces it with a hysteresis FSM and
// publishes a qualified level, registered rise/fall pulses and a saturating event count.
module and3_event_qualifier #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  and3_event_qualifier_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARM    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_DISARM = 2'd3;

  localparam logic [7:0]           DEB_LIMIT = 8'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 sync1_q;
  logic                 sync2_q;
  logic [1:0]           state_q, state_d;
  logic [7:0]           timer_q, timer_d;
  logic                 level_q, level_d;
  logic                 rise_q,  rise_d;
  logic                 fall_q,  fall_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 ovf_q,   ovf_d;

  // Two-flop synchroniser for the asynchronous, glitch-prone AND output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.d;
      sync2_q <= sync1_q;
    end
  end

  // Hysteresis FSM: a level change needs DEBOUNCE_CYCLES+1 consecutive opposite samples.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!bus.en) begin
      state_d = ST_IDLE;
      timer_d = 8'd0;
      level_d = 1'b0;
      fall_d  = (state_q == ST_ACTIVE) || (state_q == ST_DISARM);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sync2_q) begin
            state_d = ST_ARM;
            timer_d = 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARM: begin
          if (!sync2_q) begin
            state_d = ST_IDLE;
            timer_d = 8'd0;
          end else if (timer_q == DEB_LIMIT) begin
            state_d = ST_ACTIVE;
            timer_d = 8'd0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        ST_ACTIVE: begin
          if (!sync2_q) begin
            state_d = ST_DISARM;
            timer_d = 8'd1;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_DISARM: begin
          if (sync2_q) begin
            state_d = ST_ACTIVE;
            timer_d = 8'd0;
          end else if (timer_q == DEB_LIMIT) begin
            state_d = ST_IDLE;
            timer_d = 8'd0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = 8'd0;
          level_d = 1'b0;
        end
      endcase
    end
  end

  // Event counter: clr takes priority over a coincident rise; ovf is sticky.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      count_d = {CNT_WIDTH{1'b0}};
      ovf_d   = 1'b0;
    end else if (rise_d) begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + CNT_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // State, timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= 8'd0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= {CNT_WIDTH{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.q     = level_q;
  assign bus.rise  = rise_q;
  assign bus.fall  = fall_q;
  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_and3_event_qualifier.sv
// Scoreboard bench: a run-length reference model predicts outputs per edge;
// predictions are queued when inputs are driven and compared after the edge.
module tb_and3_event_qualifier;

  localparam int D  = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic          q;
    logic          rise;
    logic          fall;
    logic [CW-1:0] count;
    logic          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  and3_event_qualifier_if #(.CNT_WIDTH(CW)) bus_if ();

  and3_event_qualifier #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: synchroniser pipe plus count of consecutive samples disagreeing with q.
  logic          m_s1, m_s2, m_q, m_ovf;
  int            m_run;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1  = 1'b0;
    m_s2  = 1'b0;
    m_q   = 1'b0;
    m_ovf = 1'b0;
    m_run = 0;
    m_cnt = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_q"},     16'(bus_if.q),     16'd0);
    chk({tag, "_rise"},  16'(bus_if.rise),  16'd0);
    chk({tag, "_fall"},  16'(bus_if.fall),  16'd0);
    chk({tag, "_count"}, 16'(bus_if.count), 16'd0);
    chk({tag, "_ovf"},   16'(bus_if.ovf),   16'd0);
  endtask

  task automatic tick(input logic d_v, input logic en_v, input logic clr_v, input string tag);
    exp_t e;
    exp_t got;
    logic ds;
    logic r;
    logic f;
    @(negedge clk);
    bus_if.d   = d_v;
    bus_if.en  = en_v;
    bus_if.clr = clr_v;
    ds = m_s2;
    r  = 1'b0;
    f  = 1'b0;
    if (!en_v) begin
      f     = m_q;
      m_q   = 1'b0;
      m_run = 0;
    end else if (ds != m_q) begin
      m_run++;
      if (m_run == D + 1) begin
        r     = ~m_q;
        f     = m_q;
        m_q   = ~m_q;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    if (clr_v) begin
      m_cnt = '0;
      m_ovf = 1'b0;
    end else if (r) begin
      if (m_cnt == {CW{1'b1}}) m_ovf = 1'b1;
      else m_cnt = m_cnt + 1'b1;
    end
    m_s2 = m_s1;
    m_s1 = d_v;
    e.q = m_q; e.rise = r; e.fall = f; e.count = m_cnt; e.ovf = m_ovf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      got = sb_q.pop_front();
      chk({tag, "_q"},     16'(bus_if.q),     16'(got.q));
      chk({tag, "_rise"},  16'(bus_if.rise),  16'(got.rise));
      chk({tag, "_fall"},  16'(bus_if.fall),  16'(got.fall));
      chk({tag, "_count"}, 16'(bus_if.count), 16'(got.count));
      chk({tag, "_ovf"},   16'(bus_if.ovf),   16'(got.ovf));
    end
  endtask

  task automatic run(input logic d_v, input logic en_v, input logic clr_v, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(d_v, en_v, clr_v, tag);
  endtask

  initial begin
    bus_if.d   = 1'b0;
    bus_if.en  = 1'b0;
    bus_if.clr = 1'b0;
    rst_n      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic latency: rise expected on the 7th edge with d held high.
    run(1'b1, 1'b1, 1'b0, 10, "t1");
    chk("t1_count", 16'(bus_if.count), 16'd1);

    // Short glitches in ARM and short dips in ACTIVE are absorbed.
    run(1'b0, 1'b1, 1'b0, 10, "t2_fall");
    run(1'b1, 1'b1, 1'b0, 3,  "t2_glitch");
    run(1'b0, 1'b1, 1'b0, 8,  "t2_low");
    chk("t2_cnt_held", 16'(bus_if.count), 16'd1);
    run(1'b1, 1'b1, 1'b0, 10, "t2_act");
    run(1'b0, 1'b1, 1'b0, 3,  "t2_dip");
    run(1'b1, 1'b1, 1'b0, 6,  "t2_back");
    chk("t2_q_held", 16'(bus_if.q), 16'd1);

    // Saturation and sticky overflow with a 2-bit counter, then clear.
    tick(1'b0, 1'b1, 1'b1, "t3_clr");
    run(1'b0, 1'b1, 1'b0, 9, "t3_settle");
    for (int p = 0; p < 5; p++) begin
      run(1'b1, 1'b1, 1'b0, 8, "t3_hi");
      run(1'b0, 1'b1, 1'b0, 8, "t3_lo");
    end
    chk("t3_sat_count", 16'(bus_if.count), 16'd3);
    chk("t3_sat_ovf",   16'(bus_if.ovf),   16'd1);
    tick(1'b0, 1'b1, 1'b1, "t3_clr2");
    chk("t3_clr_count", 16'(bus_if.count), 16'd0);
    chk("t3_clr_ovf",   16'(bus_if.ovf),   16'd0);

    // clr coincident with a rise: pulse still fires, count is cleared.
    run(1'b1, 1'b1, 1'b0, 8, "t4_pre");
    run(1'b0, 1'b1, 1'b0, 8, "t4_lo");
    run(1'b1, 1'b1, 1'b0, 6, "t4_arm");
    tick(1'b1, 1'b1, 1'b1, "t4_edge");
    chk("t4_rise",  16'(bus_if.rise),  16'd1);
    chk("t4_count", 16'(bus_if.count), 16'd0);
    chk("t4_ovf",   16'(bus_if.ovf),   16'd0);
    run(1'b1, 1'b1, 1'b0, 3, "t4_post");

    // Dropping en in ACTIVE forces a fall; re-qualification takes D+1 edges.
    tick(1'b1, 1'b0, 1'b0, "t5_off");
    chk("t5_off_q",    16'(bus_if.q),    16'd0);
    chk("t5_off_fall", 16'(bus_if.fall), 16'd1);
    run(1'b1, 1'b1, 1'b0, D, "t5_wait");
    chk("t5_wait_q", 16'(bus_if.q), 16'd0);
    tick(1'b1, 1'b1, 1'b0, "t5_rise");
    chk("t5_rise_q",   16'(bus_if.q),     16'd1);
    chk("t5_rise_p",   16'(bus_if.rise),  16'd1);
    chk("t5_rise_cnt", 16'(bus_if.count), 16'd1);

    // Asynchronous reset mid-ARM, then full latency after release.
    run(1'b0, 1'b1, 1'b0, 10, "t6_idle");
    run(1'b1, 1'b1, 1'b0, 4,  "t6_arm");
    #2;
    rst_n    = 1'b0;
    bus_if.d = 1'b0;
    #1;
    check_all_zero("t6_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, 1'b1, 1'b0, D + 2, "t6_lat");
    chk("t6_lat_q", 16'(bus_if.q), 16'd0);
    tick(1'b1, 1'b1, 1'b0, "t6_rise");
    chk("t6_rise_q", 16'(bus_if.q),    16'd1);
    chk("t6_rise_p", 16'(bus_if.rise), 16'd1);
    chk("t6_sb_drained", 16'(sb_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
